// File: rtl/fp_norm_pkg.sv
// Shared constants for the FP multiplier normalisation pipeline:
// default field widths and the bit positions of the result flags.
package fp_norm_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 24;

  localparam int FLAG_W    = 3;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_OF   = 2;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/lzc_prio.sv
// Priority leading-zero counter: cnt is the number of zeros above the
// highest set bit of d, or W when d is all zero.
module lzc_prio #(
  parameter int W  = 48,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt,
  output logic          all_zero
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = CW'(W - 1 - i);
    end
  end

  assign all_zero = ~|d;

endmodule

// File: rtl/fp_mul_norm_pipe.sv
// Two-stage normaliser for a raw significand product: S1 finds the leading
// one, S2 shifts it to bit PW-2, adjusts the exponent and raises flags.
module fp_mul_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int  EXP_W = DEF_EXP_W,
  parameter int  MAN_W = DEF_MAN_W,
  parameter int  TAG_W = 4,
  localparam int PW    = 2 * MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_e,
  input  logic [PW-1:0]    in_m,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_e,
  output logic [PW-1:0]    out_m,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_uf,
  output logic             out_of
);

  localparam int LZ_W = $clog2(PW + 1);
  localparam int XW   = EXP_W + 2;
  localparam logic signed [XW-1:0] E_MAX = XW'((1 << EXP_W) - 1);

  // Handshake: a word moves across a port only in a cycle where valid and
  // ready are both high. A stage loads when it is empty or its content
  // moves on this cycle; in_ready never looks at in_valid.
  logic s1_valid, s2_load, s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // ---------------- S1: leading-one detect ----------------
  logic [LZ_W-1:0]  lz;
  logic             lz_zero;
  logic [EXP_W-1:0] s1_e;
  logic [PW-1:0]    s1_m;
  logic [TAG_W-1:0] s1_tag;
  logic [LZ_W-1:0]  s1_lz;
  logic             s1_zero;

  lzc_prio #(.W(PW), .CW(LZ_W)) u_lzc (
    .d        (in_m),
    .cnt      (lz),
    .all_zero (lz_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
      s1_tag   <= '0;
      s1_lz    <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_e    <= in_e;
        s1_m    <= in_m;
        s1_tag  <= in_tag;
        s1_lz   <= lz;
        s1_zero <= lz_zero;
      end
    end
  end

  // ---------------- S2: shift, exponent adjust, flags ----------------
  // With lz leading zeros the target shift is left by lz-1 (right by one
  // when lz is 0), so the exponent adjust is uniformly 1 - lz.
  logic signed [XW-1:0] e_sum;
  logic [PW-1:0]        m_shift;
  logic [EXP_W-1:0]     n_e;
  logic [PW-1:0]        n_m;
  flags_t               n_flags;

  assign e_sum   = XW'(s1_e) + XW'(1) - XW'(s1_lz);
  assign m_shift = (s1_lz == '0) ? (s1_m >> 1) : (s1_m << (s1_lz - LZ_W'(1)));

  always_comb begin
    n_e     = '0;
    n_m     = '0;
    n_flags = '0;
    if (s1_zero) begin
      n_flags[FLAG_ZERO] = 1'b1;
    end else if (e_sum <= 0) begin
      n_flags[FLAG_UF] = 1'b1;
    end else if (e_sum >= E_MAX) begin
      n_flags[FLAG_OF] = 1'b1;
      n_e              = '1;
    end else begin
      n_e = e_sum[EXP_W-1:0];
      n_m = m_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_e     <= '0;
      out_m     <= '0;
      out_tag   <= '0;
      out_zero  <= 1'b0;
      out_uf    <= 1'b0;
      out_of    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_e    <= n_e;
        out_m    <= n_m;
        out_tag  <= s1_tag;
        out_zero <= n_flags[FLAG_ZERO];
        out_uf   <= n_flags[FLAG_UF];
        out_of   <= n_flags[FLAG_OF];
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_pipe.sv
// Directed bench for fp_mul_norm_pipe: vector table, back-to-back stream
// with output stall, and reset with operands in flight.
module tb_fp_mul_norm_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int TAG_W = 4;
  localparam int PW    = 2 * MAN_W;
  localparam int RW    = TAG_W + EXP_W + PW + 3;
  localparam int NV    = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [EXP_W-1:0] in_e = '0;
  logic [PW-1:0]    in_m = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [EXP_W-1:0] out_e;
  logic [PW-1:0]    out_m;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero, out_uf, out_of;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [EXP_W-1:0] e;
    logic [PW-1:0]    m;
    logic [TAG_W-1:0] tag;
    logic [EXP_W-1:0] xe;
    logic [PW-1:0]    xm;
    logic [2:0]       xflags;  // {zero, uf, of}
  } vec_t;

  vec_t vecs[NV];
  logic [RW-1:0] exp_q[$];

  fp_mul_norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_e      (in_e),
    .in_m      (in_m),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_e     (out_e),
    .out_m     (out_m),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_uf    (out_uf),
    .out_of    (out_of)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_exp(input vec_t v);
    return {v.tag, v.xe, v.xm, v.xflags};
  endfunction

  function automatic logic [RW-1:0] pack_out();
    return {out_tag, out_e, out_m, out_zero, out_uf, out_of};
  endfunction

  function automatic vec_t mk(input logic [EXP_W-1:0] e, input logic [PW-1:0] m,
                              input logic [TAG_W-1:0] tag, input logic [EXP_W-1:0] xe,
                              input logic [PW-1:0] xm, input logic [2:0] xflags);
    vec_t v;
    v.e = e; v.m = m; v.tag = tag; v.xe = xe; v.xm = xm; v.xflags = xflags;
    return v;
  endfunction

  // Single operand with out_ready high: checks acceptance, latency and result.
  task automatic send_one(input vec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_e = v.e; in_m = v.m; in_tag = v.tag;
    @(negedge clk);
    check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check($sformatf("v%0d_latency", idx), lat, 2);
    check($sformatf("v%0d_e", idx), out_e, v.xe);
    check($sformatf("v%0d_m", idx), out_m, v.xm);
    check($sformatf("v%0d_tag", idx), out_tag, v.tag);
    check($sformatf("v%0d_flags", idx), {out_zero, out_uf, out_of}, v.xflags);
  endtask

  initial begin
    logic [RW-1:0] snap;
    logic [RW-1:0] exp_r;
    int got, g, vcount;
    logic acc;

    vecs[0]  = mk(8'h80, 48'h4000_0000_0000, 4'h3, 8'h80, 48'h4000_0000_0000, 3'b000);
    vecs[1]  = mk(8'h7F, 48'h8000_0000_0000, 4'h5, 8'h80, 48'h4000_0000_0000, 3'b000);
    vecs[2]  = mk(8'hFE, 48'h8000_0000_0000, 4'h6, 8'hFF, 48'h0,             3'b001);
    vecs[3]  = mk(8'h80, 48'h0000_0000_0001, 4'h7, 8'h52, 48'h4000_0000_0000, 3'b000);
    vecs[4]  = mk(8'h80, 48'h0,              4'h8, 8'h00, 48'h0,             3'b100);
    vecs[5]  = mk(8'h10, 48'h0000_0100_0000, 4'h9, 8'h00, 48'h0,             3'b010);
    vecs[6]  = mk(8'h01, 48'hC000_0000_0001, 4'hA, 8'h02, 48'h6000_0000_0000, 3'b000);
    vecs[7]  = mk(8'h17, 48'h0000_0100_0000, 4'hB, 8'h01, 48'h4000_0000_0000, 3'b000);
    vecs[8]  = mk(8'h16, 48'h0000_0100_0000, 4'hC, 8'h00, 48'h0,             3'b010);
    vecs[9]  = mk(8'hFF, 48'h4000_0000_0000, 4'hD, 8'hFF, 48'h0,             3'b001);
    vecs[10] = mk(8'hFE, 48'h4000_0000_0000, 4'hE, 8'hFE, 48'h4000_0000_0000, 3'b000);
    vecs[11] = mk(8'h40, 48'h0123_4567_89AB, 4'hF, 8'h3A, 48'h48D1_59E2_6AC0, 3'b000);

    // Clock/reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_e", out_e, 0);
    check("rst_out_m", out_m, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", {out_zero, out_uf, out_of}, 0);

    // Table-driven single operands
    for (int i = 0; i < NV; i++) send_one(vecs[i], i);

    // Back-to-back stream of 5 with a 3-cycle output stall
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin : driver
        for (int i = 0; i < 5; i++) begin
          in_valid = 1'b1; in_e = vecs[i].e; in_m = vecs[i].m; in_tag = vecs[i].tag;
          acc = 1'b0; g = 0;
          while (!acc && g < 30) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(pack_exp(vecs[i]));
            #1;
            g++;
          end
          if (!acc) check($sformatf("drv_accept_%0d", i), 0, 1);
        end
        in_valid = 1'b0;
      end
      begin : monitor
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!out_valid && g < 20);
        check("stall_first_valid", out_valid, 1);
        snap = pack_out();
        check("stall_in_ready_0", in_ready, 0);
        for (int k = 1; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("stall_valid_%0d", k), out_valid, 1);
          check($sformatf("stall_stable_%0d", k), pack_out(), snap);
          check($sformatf("stall_in_ready_%0d", k), in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 0; g = 0;
        while (got < 5 && g < 40) begin
          @(negedge clk);
          g++;
          if (out_valid) begin
            if (exp_q.size() == 0) begin
              check($sformatf("stream_extra_%0d", got), 1, 0);
            end else begin
              exp_r = exp_q.pop_front();
              check($sformatf("stream_res_%0d", got), pack_out(), exp_r);
            end
            got++;
          end
        end
        check("stream_count", got, 5);
      end
    join
    check("stream_q_empty", exp_q.size(), 0);

    // Reset with two operands in flight and the output stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_e = vecs[0].e; in_m = vecs[0].m; in_tag = vecs[0].tag;
    @(posedge clk); #1;
    in_e = vecs[1].e; in_m = vecs[1].m; in_tag = vecs[1].tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("rst_mid_no_stale", vcount, 0);

    send_one(vecs[11], 100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fp_mul_norm_pipe.md
FP_MUL_NORM_PIPE -- requirements
Module: fp_mul_norm_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 The block SHALL have parameter MAN_W, default 24, significand width including hidden bit; product width PW = 2*MAN_W.
REQ-003 The block SHALL have parameter TAG_W, default 4, sideband tag width carried alongside each operand.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand valid; in_ready  output  1  block can accept.
REQ-006 in_e  input  EXP_W  biased exponent sum; in_m  input  PW  raw significand product; in_tag  input  TAG_W  sideband.
REQ-007 out_valid  output  1  result valid; out_ready  input  1  downstream accepts.
REQ-008 out_e  output  EXP_W  normalised exponent; out_m  output  PW  normalised product, leading one at bit PW-2.
REQ-009 out_tag  output  TAG_W  tag of this result; out_zero, out_uf, out_of  output  1 each  zero/underflow/overflow flags.

Function
REQ-010 Transfer on a port SHALL occur only in a cycle where valid and ready are both high.
REQ-011 Pipeline SHALL be two registered stages: S1 = leading-one detect and shift-amount computation; S2 = shift, exponent adjust, flags.
REQ-012 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput one result per cycle.
REQ-013 S2 SHALL load when S2 empty or out_ready high; S1 SHALL load when S1 empty or S2 loads; in_ready = S1 empty or S2 loads (combinational, no dependence on in_valid).
REQ-014 While out_valid high and out_ready low, out_* SHALL hold stable; no result is dropped or duplicated; order SHALL be preserved.
REQ-015 If in_m[PW-1]=1: out_m = in_m >> 1, exponent adjust +1.
REQ-016 Else if leading one at bit k (k <= PW-2): out_m = in_m << (PW-2-k), exponent adjust -(PW-2-k); full range 0..PW-2, no shift cap.
REQ-017 Exponent arithmetic SHALL be signed with EXP_W+2 bits: e' = in_e + adjust.
REQ-018 If in_m = 0: out_zero=1, out_e=0, out_m=0, out_uf=out_of=0.
REQ-019 Else if e' <= 0: out_uf=1, out_e=0, out_m=0 (flush to zero).
REQ-020 Else if e' >= 2^EXP_W-1: out_of=1, out_e=all ones, out_m=0.
REQ-021 Otherwise out_e = e'[EXP_W-1:0], flags 0; at most one flag SHALL be set per result.
REQ-022 out_tag SHALL equal in_tag of the same transfer.

Reset
REQ-023 While rst high, both stage valids, out_valid, flags, out_e, out_m, out_tag SHALL be 0 at the next edge; in_ready SHALL be 1 after reset.
REQ-024 Reset mid-operation SHALL discard all in-flight results; no result emitted for operands accepted before reset.
REQ-025 Data registers MAY load during stall only when their stage load enable is high.

Structure
REQ-026 A shared package fp_norm_pkg SHALL hold default EXP_W/MAN_W constants and the flag-encoding constants.
REQ-027 Leading-one detection SHALL be a sub-module lzc_prio (parametrised width, outputs count and all-zero flag), instantiated once in S1.
REQ-028 No latches; all arithmetic width-explicit; RTL target 150-300 lines.

Verification (EXP_W=8, MAN_W=24)
REQ-029 in_m=0x4000_0000_0000, in_e=0x80, tag=3 -> 2 cycles later out_m=0x4000_0000_0000, out_e=0x80, tag=3, flags 0.
REQ-030 in_m=0x8000_0000_0000, in_e=0x7F -> out_m=0x4000_0000_0000, out_e=0x80; same in_m with in_e=0xFE -> out_of=1, out_e=0xFF, out_m=0.
REQ-031 in_m=0x0000_0000_0001, in_e=0x80 -> out_m=0x4000_0000_0000, out_e=0x52; in_m=0 -> out_zero=1, out_e=0, out_m=0.
REQ-032 in_m=0x0000_0100_0000, in_e=0x10 (shift 22, e'=-6) -> out_uf=1, out_e=0, out_m=0.
REQ-033 Back-to-back 5 operands, out_ready low for 3 cycles after first out_valid -> in_ready low once both stages full, outputs held stable, all 5 results delivered in order with correct tags.
REQ-034 rst asserted one cycle with 2 operands in flight -> out_valid 0 next cycle, in_ready 1, no stale result appears afterwards.
